mul_rs_dispatch: RTL and testbench
==================================

// Module: mul_rs_dispatch
// PURPOSE
//  Multiply/divide reservation station feeding the mul/div execution unit.
//  Holds up to NUM_ENTRIES issued MUL/DIV ops and captures operands from CDB broadcasts.
//  Dispatches the oldest fully-ready entry whenever the exec unit is idle.
//  Frees the entry when the exec unit reports completion.
// PARAMETERS
//  NUM_ENTRIES  3  station depth (2..8)
//  DATA_W       8  operand width
//  TAG_W        3  ROB index / producer tag width
//  REG_W        4  architectural register index width
// PORTS
//  clk1            in   1            rising-edge clock
//  rst             in   1            synchronous active-high reset
//  iss_valid       in   1            issue request
//  iss_ready       out  1            station has a free entry; accepted = valid & ready
//  iss_func        in   4            4'b0010 MUL, 4'b0011 DIV
//  iss_rd          in   REG_W        destination register
//  iss_rob         in   TAG_W        ROB index of this op
//  iss_s1_rdy      in   1            src1 value valid; else iss_s1_tag names the producer
//  iss_s1_val      in   DATA_W       src1 value
//  iss_s1_tag      in   TAG_W        src1 producer tag
//  iss_s2_rdy, iss_s2_val, iss_s2_tag  in  1/DATA_W/TAG_W  same for src2
//  cdb_valid       in   1            result broadcast
//  cdb_tag         in   TAG_W        producing ROB index
//  cdb_data        in   2*DATA_W     result; low DATA_W bits are captured
//  ex_busy         in   1            exec unit occupied
//  ex_done         in   1            exec unit finished the entry in ex_done_idx
//  ex_done_idx     in   $clog2(NUM_ENTRIES)  entry to free
//  ex_b            out  1            dispatch strobe, one cycle
//  ex_rs_index     out  $clog2(NUM_ENTRIES)  dispatched entry
//  ex_rs1_data, ex_rs2_data  out  DATA_W  operands
//  ex_func / ex_rd / ex_rob_ind  out  4/REG_W/TAG_W  op fields
//  occupancy       out  $clog2(NUM_ENTRIES+1)  entries not FREE
//  illegal_func    out  1            pulse: issue rejected, func not MUL/DIV
// BEHAVIOUR
//  - Reset: all entries FREE; every output 0 except iss_ready=1; age matrix cleared.
//  - Per-entry FSM: FREE -issue-> WAIT (src missing) or READY (both valid);
//    WAIT -CDB fills last src-> READY; READY -selected-> EXEC; EXEC -ex_done(idx)-> FREE.
//  - Issue allocates the lowest-index FREE entry. Illegal func: illegal_func=1,
//    nothing allocated, iss_ready unaffected.
//  - Wakeup: any WAIT source with matching tag captures cdb_data[DATA_W-1:0] at the edge.
//    Both sources can match the same broadcast.
//  - Select: combinational over READY entries; oldest by age matrix.
//    Entry issued earlier wins; matrix is updated on alloc and free.
//  - Dispatch: registered. When !ex_busy, and no ex_b was asserted in the previous cycle,
//    ex_b=1 for one cycle with the selected entry's fields; the entry moves to EXEC.
//  - Latency: an entry READY at edge N dispatches at edge N+1 at the earliest.
//    A READY entry cannot dispatch in the same cycle it is issued.
//  - Full: iss_ready=0 when no FREE entry. An ex_done in the same cycle does not
//    raise iss_ready until the next cycle.
//  - Simultaneous ex_done + issue: the freed index is reusable from the next cycle.
//  - ex_done for an index not in EXEC: ignored.
//  - rst mid-operation: all entries dropped, ex_b deasserted the same edge.
//  - occupancy is registered, updated with the FSM.
// CONFIGURATION
//  MUL_RS_CDB_BYPASS_EN defined: at issue, a source with iss_sN_rdy=0 and
//    iss_sN_tag==cdb_tag while cdb_valid=1 is captured as ready from cdb_data.
//  Not defined: that source enters WAIT and waits for a later broadcast
//    (the producer has already broadcast, so the system must avoid this case).
// TESTING
//  - Reset, issue MUL 3*5 (both ready, rob=2, rs idx 0) -> ex_b pulse next cycle with
//    ex_rs1_data=3, ex_rs2_data=5, ex_func=0010, ex_rob_ind=2, ex_rs_index=0.
//  - Issue DIV, src1 tag=4 not ready; cdb_valid tag=4 data=16'h0012 two cycles later
//    -> dispatch the following cycle with ex_rs1_data=8'h12.
//  - Fill 3 entries while ex_busy=1 -> iss_ready=0, occupancy=3.
//    Release ex_busy -> dispatch order follows issue order, not index order.
//  - ex_done idx 1 plus new issue in the same cycle -> new op lands in entry 1
//    one cycle later; occupancy stays consistent.
//  - Issue func=4'b0001 -> illegal_func pulse; occupancy unchanged; no ex_b.
//  - With MUL_RS_CDB_BYPASS_EN: issue with src tag == broadcasting cdb_tag ->
//    entry READY immediately and dispatched next cycle.

Source files
------------

// File: rtl/mul_rs_dispatch.sv
// mul_rs_dispatch: mul/div reservation station with age-ordered registered dispatch; define MUL_RS_CDB_BYPASS_EN to capture a same-cycle CDB result at issue
module mul_rs_dispatch #(
    parameter int NUM_ENTRIES = 3,
    parameter int DATA_W = 8,
    parameter int TAG_W = 3,
    parameter int REG_W = 4,
    localparam int IDX_W = $clog2(NUM_ENTRIES),
    localparam int OCC_W = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                iss_valid,
    output logic                iss_ready,
    input  logic [3:0]          iss_func,
    input  logic [REG_W-1:0]    iss_rd,
    input  logic [TAG_W-1:0]    iss_rob,
    input  logic                iss_s1_rdy,
    input  logic [DATA_W-1:0]   iss_s1_val,
    input  logic [TAG_W-1:0]    iss_s1_tag,
    input  logic                iss_s2_rdy,
    input  logic [DATA_W-1:0]   iss_s2_val,
    input  logic [TAG_W-1:0]    iss_s2_tag,
    input  logic                cdb_valid,
    input  logic [TAG_W-1:0]    cdb_tag,
    input  logic [2*DATA_W-1:0] cdb_data,
    input  logic                ex_busy,
    input  logic                ex_done,
    input  logic [IDX_W-1:0]    ex_done_idx,
    output logic                ex_b,
    output logic [IDX_W-1:0]    ex_rs_index,
    output logic [DATA_W-1:0]   ex_rs1_data,
    output logic [DATA_W-1:0]   ex_rs2_data,
    output logic [3:0]          ex_func,
    output logic [REG_W-1:0]    ex_rd,
    output logic [TAG_W-1:0]    ex_rob_ind,
    output logic [OCC_W-1:0]    occupancy,
    output logic                illegal_func
);
    typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} state_e;
    typedef struct packed {
        state_e             st;
        logic [3:0]         func;
        logic [REG_W-1:0]   rd;
        logic [TAG_W-1:0]   rob;
        logic               r1;
        logic               r2;
        logic [DATA_W-1:0]  v1;
        logic [DATA_W-1:0]  v2;
        logic [TAG_W-1:0]   t1;
        logic [TAG_W-1:0]   t2;
    } ent_t;
    typedef struct packed {
        logic               b;
        logic [IDX_W-1:0]   idx;
        logic [DATA_W-1:0]  d1;
        logic [DATA_W-1:0]  d2;
        logic [3:0]         func;
        logic [REG_W-1:0]   rd;
        logic [TAG_W-1:0]   rob;
        logic               ill;
        logic [OCC_W-1:0]   occ;
    } out_t;
    ent_t ent_q [NUM_ENTRIES];
    ent_t ent_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] oldest;
    out_t out_q, out_d;
    logic legal, free_any, alloc, dispatch, byp1, byp2;
    logic [IDX_W-1:0] alloc_idx, sel_idx;
    logic [DATA_W-1:0] cdb_lo;
    logic unused_cdb_hi;
    assign cdb_lo = cdb_data[DATA_W-1:0];
    assign unused_cdb_hi = ^cdb_data[2*DATA_W-1:DATA_W];
    assign iss_ready = free_any;
    assign ex_b = out_q.b;
    assign ex_rs_index = out_q.idx;
    assign ex_rs1_data = out_q.d1;
    assign ex_rs2_data = out_q.d2;
    assign ex_func = out_q.func;
    assign ex_rd = out_q.rd;
    assign ex_rob_ind = out_q.rob;
    assign occupancy = out_q.occ;
    assign illegal_func = out_q.ill;
    always_comb begin
        legal = iss_func == 4'b0010 || iss_func == 4'b0011;
        free_any = 1'b0;
        alloc_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (ent_q[i].st == FREE) begin
                free_any = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
        alloc = iss_valid && free_any && legal;
        oldest = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            oldest[i] = ent_q[i].st == READY;
            for (int j = 0; j < NUM_ENTRIES; j++)
                if (j != i && ent_q[j].st == READY && older_q[j][i]) oldest[i] = 1'b0;
        end
        sel_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (oldest[i]) sel_idx = IDX_W'(i);
        dispatch = |oldest && !ex_busy && !out_q.b;
`ifdef MUL_RS_CDB_BYPASS_EN
        byp1 = cdb_valid && !iss_s1_rdy && iss_s1_tag == cdb_tag;
        byp2 = cdb_valid && !iss_s2_rdy && iss_s2_tag == cdb_tag;
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        out_d = out_q;
        out_d.b = dispatch;
        out_d.ill = iss_valid && !legal;
        if (dispatch) begin
            out_d.idx = sel_idx;
            out_d.d1 = ent_q[sel_idx].v1;
            out_d.d2 = ent_q[sel_idx].v2;
            out_d.func = ent_q[sel_idx].func;
            out_d.rd = ent_q[sel_idx].rd;
            out_d.rob = ent_q[sel_idx].rob;
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_d[i] = ent_q[i];
            older_d[i] = older_q[i];
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_q[i].st == WAIT && cdb_valid) begin
                if (!ent_q[i].r1 && ent_q[i].t1 == cdb_tag) begin
                    ent_d[i].r1 = 1'b1;
                    ent_d[i].v1 = cdb_lo;
                end
                if (!ent_q[i].r2 && ent_q[i].t2 == cdb_tag) begin
                    ent_d[i].r2 = 1'b1;
                    ent_d[i].v2 = cdb_lo;
                end
                if (ent_d[i].r1 && ent_d[i].r2) ent_d[i].st = READY;
            end
            if (dispatch && sel_idx == IDX_W'(i)) ent_d[i].st = EXEC;
            if (ex_done && ex_done_idx == IDX_W'(i) && ent_q[i].st == EXEC) begin
                ent_d[i].st = FREE;
                older_d[i] = '0;
                for (int j = 0; j < NUM_ENTRIES; j++) older_d[j][i] = 1'b0;
            end
            if (alloc && alloc_idx == IDX_W'(i)) begin
                ent_d[i].func = iss_func;
                ent_d[i].rd = iss_rd;
                ent_d[i].rob = iss_rob;
                ent_d[i].r1 = iss_s1_rdy || byp1;
                ent_d[i].r2 = iss_s2_rdy || byp2;
                ent_d[i].v1 = byp1 ? cdb_lo : iss_s1_val;
                ent_d[i].v2 = byp2 ? cdb_lo : iss_s2_val;
                ent_d[i].t1 = iss_s1_tag;
                ent_d[i].t2 = iss_s2_tag;
                ent_d[i].st = ent_d[i].r1 && ent_d[i].r2 ? READY : WAIT;
                older_d[i] = '0;
                for (int j = 0; j < NUM_ENTRIES; j++)
                    if (j != i) older_d[j][i] = 1'b1;
            end
        end
        out_d.occ = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            if (ent_d[i].st != FREE) out_d.occ = out_d.occ + OCC_W'(1);
    end
    always_ff @(posedge clk1) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
                older_q[i] <= '0;
            end
            out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
                older_q[i] <= older_d[i];
            end
            out_q <= out_d;
        end
    end
endmodule

// File: tb/tb_mul_rs_dispatch.sv
// tb_mul_rs_dispatch: directed scenarios plus randomized traffic against a queue-based reference model
module tb_mul_rs_dispatch;
    localparam int N = 3;
    localparam int S_FREE = 0, S_WAIT = 1, S_READY = 2, S_EXEC = 3;
    logic clk1 = 1'b0;
    logic rst;
    logic iss_valid, iss_ready, iss_s1_rdy, iss_s2_rdy;
    logic [3:0] iss_func, iss_rd;
    logic [2:0] iss_rob, iss_s1_tag, iss_s2_tag;
    logic [7:0] iss_s1_val, iss_s2_val;
    logic cdb_valid;
    logic [2:0] cdb_tag;
    logic [15:0] cdb_data;
    logic ex_busy, ex_done;
    logic [1:0] ex_done_idx;
    logic ex_b, illegal_func;
    logic [1:0] ex_rs_index, occupancy;
    logic [7:0] ex_rs1_data, ex_rs2_data;
    logic [3:0] ex_func, ex_rd;
    logic [2:0] ex_rob_ind;
    int n_tests = 0, n_fail = 0;
    int m_st [N];
    bit m_r1 [N], m_r2 [N];
    logic [7:0] m_v1 [N], m_v2 [N];
    logic [2:0] m_t1 [N], m_t2 [N], m_rob [N];
    logic [3:0] m_func [N], m_rd [N];
    int m_age [$];
    bit m_exb, e_exb, e_ill;
    int e_occ;
    logic [28:0] e_pkt;

    mul_rs_dispatch dut (
        .clk1(clk1), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_func(iss_func), .iss_rd(iss_rd), .iss_rob(iss_rob),
        .iss_s1_rdy(iss_s1_rdy), .iss_s1_val(iss_s1_val), .iss_s1_tag(iss_s1_tag),
        .iss_s2_rdy(iss_s2_rdy), .iss_s2_val(iss_s2_val), .iss_s2_tag(iss_s2_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_busy(ex_busy), .ex_done(ex_done), .ex_done_idx(ex_done_idx),
        .ex_b(ex_b), .ex_rs_index(ex_rs_index), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_func(ex_func), .ex_rd(ex_rd),
        .ex_rob_ind(ex_rob_ind), .occupancy(occupancy), .illegal_func(illegal_func)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_func = 0; iss_rd = 0; iss_rob = 0;
        iss_s1_rdy = 0; iss_s1_val = 0; iss_s1_tag = 0;
        iss_s2_rdy = 0; iss_s2_val = 0; iss_s2_tag = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        ex_busy = 0; ex_done = 0; ex_done_idx = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic issue(input logic [3:0] f, input logic [3:0] rd, input logic [2:0] rob,
                         input logic r1, input logic [7:0] v1, input logic [2:0] t1,
                         input logic r2, input logic [7:0] v2, input logic [2:0] t2);
        iss_valid = 1; iss_func = f; iss_rd = rd; iss_rob = rob;
        iss_s1_rdy = r1; iss_s1_val = v1; iss_s1_tag = t1;
        iss_s2_rdy = r2; iss_s2_val = v2; iss_s2_tag = t2;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (ex_b !== 1'b0) begin n_fail++; $display("FAIL reset_ex_b got %b want 0", ex_b); end
        n_tests++; if (iss_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iss_ready got %b want 1", iss_ready); end
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        n_tests++; if (illegal_func !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal_func); end
        n_tests++;
        if ({ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func, ex_rd, ex_rob_ind} !== 29'd0) begin
            n_fail++; $display("FAIL reset_fields got %h want 0", {ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func, ex_rd, ex_rob_ind});
        end
    endtask

    task automatic test_mul();
        do_reset();
        issue(4'b0010, 4'd5, 3'd2, 1, 8'd3, 3'd0, 1, 8'd5, 3'd0);
        tick();
        iss_valid = 0;
        n_tests++; if (ex_b !== 1'b0) begin n_fail++; $display("FAIL mul_same_cycle ex_b got %b want 0", ex_b); end
        n_tests++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL mul_occ got %0d want 1", occupancy); end
        tick();
        n_tests++; if (ex_b !== 1'b1) begin n_fail++; $display("FAIL mul_dispatch ex_b got %b want 1", ex_b); end
        n_tests++;
        if ({ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func, ex_rd, ex_rob_ind} !== {2'd0, 8'd3, 8'd5, 4'b0010, 4'd5, 3'd2}) begin
            n_fail++; $display("FAIL mul_fields got idx=%0d a=%0d b=%0d f=%b rd=%0d rob=%0d want idx=0 a=3 b=5 f=0010 rd=5 rob=2",
                               ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func, ex_rd, ex_rob_ind);
        end
        tick();
        n_tests++; if (ex_b !== 1'b0) begin n_fail++; $display("FAIL mul_pulse_width ex_b got %b want 0", ex_b); end
        ex_done = 1; ex_done_idx = 0;
        tick();
        ex_done = 0;
        n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL mul_free occ got %0d want 0", occupancy); end
    endtask

    task automatic test_wakeup();
        do_reset();
        issue(4'b0011, 4'd7, 3'd1, 0, 8'hEE, 3'd4, 1, 8'd3, 3'd0);
        tick();
        iss_valid = 0;
        cdb_valid = 1; cdb_tag = 3'd5; cdb_data = 16'h0055;
        tick();
        n_tests++; if ({ex_b, occupancy} !== {1'b0, 2'd1}) begin n_fail++; $display("FAIL wake_wrong_tag got ex_b=%b occ=%0d want 0/1", ex_b, occupancy); end
        cdb_tag = 3'd4; cdb_data = 16'hAB12;
        tick();
        cdb_valid = 0;
        n_tests++; if (ex_b !== 1'b0) begin n_fail++; $display("FAIL wake_early ex_b got %b want 0", ex_b); end
        tick();
        n_tests++;
        if ({ex_b, ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func} !== {1'b1, 2'd0, 8'h12, 8'd3, 4'b0011}) begin
            n_fail++; $display("FAIL wake_dispatch got b=%b idx=%0d a=%h b=%h f=%b want 1 0 12 03 0011",
                               ex_b, ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func);
        end
        issue(4'b0010, 4'd2, 3'd3, 0, 8'd0, 3'd6, 0, 8'd0, 3'd6);
        tick();
        iss_valid = 0;
        cdb_valid = 1; cdb_tag = 3'd6; cdb_data = 16'h0009;
        tick();
        cdb_valid = 0;
        tick();
        n_tests++;
        if ({ex_b, ex_rs_index, ex_rs1_data, ex_rs2_data} !== {1'b1, 2'd1, 8'd9, 8'd9}) begin
            n_fail++; $display("FAIL wake_both_srcs got b=%b idx=%0d a=%0d b=%0d want 1 1 9 9", ex_b, ex_rs_index, ex_rs1_data, ex_rs2_data);
        end
    endtask

    task automatic test_full_order();
        logic [2:0] want_rob [3];
        logic [1:0] want_idx [3];
        bit seen;
        want_rob = '{3'd2, 3'd3, 3'd4};
        want_idx = '{2'd1, 2'd2, 2'd0};
        do_reset();
        issue(4'b0010, 4'd1, 3'd1, 1, 8'd11, 3'd0, 1, 8'd12, 3'd0);
        tick();
        iss_valid = 0;
        tick();
        n_tests++; if ({ex_b, ex_rs_index} !== {1'b1, 2'd0}) begin n_fail++; $display("FAIL full_first got b=%b idx=%0d want 1 0", ex_b, ex_rs_index); end
        ex_busy = 1;
        issue(4'b0010, 4'd2, 3'd2, 1, 8'd21, 3'd0, 1, 8'd22, 3'd0);
        tick();
        issue(4'b0011, 4'd3, 3'd3, 1, 8'd31, 3'd0, 1, 8'd32, 3'd0);
        tick();
        iss_valid = 0;
        ex_done = 1; ex_done_idx = 0;
        tick();
        ex_done = 0;
        n_tests++; if ({iss_ready, occupancy} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL full_partial got rdy=%b occ=%0d want 1 2", iss_ready, occupancy); end
        issue(4'b0010, 4'd4, 3'd4, 1, 8'd41, 3'd0, 1, 8'd42, 3'd0);
        tick();
        iss_valid = 0;
        n_tests++; if ({iss_ready, occupancy} !== {1'b0, 2'd3}) begin n_fail++; $display("FAIL full_state got rdy=%b occ=%0d want 0 3", iss_ready, occupancy); end
        ex_busy = 0;
        for (int k = 0; k < 3; k++) begin
            seen = 0;
            for (int c = 0; c < 4 && !seen; c++) begin
                tick();
                seen = ex_b;
            end
            n_tests++;
            if (!seen) begin
                n_fail++; $display("FAIL full_order_%0d timeout waiting for ex_b", k);
            end else if ({ex_rob_ind, ex_rs_index} !== {want_rob[k], want_idx[k]}) begin
                n_fail++; $display("FAIL full_order_%0d got rob=%0d idx=%0d want rob=%0d idx=%0d", k, ex_rob_ind, ex_rs_index, want_rob[k], want_idx[k]);
            end
        end
    endtask

    task automatic test_done_reissue();
        issue(4'b0011, 4'd9, 3'd5, 1, 8'd20, 3'd0, 1, 8'd4, 3'd0);
        ex_done = 1; ex_done_idx = 1;
        n_tests++; if (iss_ready !== 1'b0) begin n_fail++; $display("FAIL reissue_pre_ready got %b want 0", iss_ready); end
        tick();
        ex_done = 0;
        n_tests++; if ({iss_ready, occupancy} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL reissue_freed got rdy=%b occ=%0d want 1 2", iss_ready, occupancy); end
        tick();
        iss_valid = 0;
        n_tests++; if ({iss_ready, occupancy} !== {1'b0, 2'd3}) begin n_fail++; $display("FAIL reissue_alloc got rdy=%b occ=%0d want 0 3", iss_ready, occupancy); end
        tick();
        n_tests++;
        if ({ex_b, ex_rs_index, ex_rob_ind} !== {1'b1, 2'd1, 3'd5}) begin
            n_fail++; $display("FAIL reissue_dispatch got b=%b idx=%0d rob=%0d want 1 1 5", ex_b, ex_rs_index, ex_rob_ind);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        issue(4'b0001, 4'd1, 3'd1, 1, 8'd1, 3'd0, 1, 8'd1, 3'd0);
        tick();
        iss_valid = 0;
        n_tests++;
        if ({illegal_func, occupancy, iss_ready, ex_b} !== {1'b1, 2'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL illegal_pulse got ill=%b occ=%0d rdy=%b ex_b=%b want 1 0 1 0", illegal_func, occupancy, iss_ready, ex_b);
        end
        tick();
        n_tests++; if ({illegal_func, ex_b} !== 2'b00) begin n_fail++; $display("FAIL illegal_after got ill=%b ex_b=%b want 0 0", illegal_func, ex_b); end
    endtask

    task automatic test_ignore_done();
        do_reset();
        ex_busy = 1;
        issue(4'b0010, 4'd3, 3'd6, 1, 8'd7, 3'd0, 1, 8'd8, 3'd0);
        tick();
        iss_valid = 0;
        ex_done = 1; ex_done_idx = 0;
        tick();
        ex_done_idx = 2;
        tick();
        ex_done = 0;
        n_tests++; if ({occupancy, ex_b} !== {2'd1, 1'b0}) begin n_fail++; $display("FAIL ignore_done got occ=%0d ex_b=%b want 1 0", occupancy, ex_b); end
        ex_busy = 0;
        tick();
        n_tests++; if ({ex_b, ex_rs_index, ex_rob_ind} !== {1'b1, 2'd0, 3'd6}) begin n_fail++; $display("FAIL ignore_dispatch got b=%b idx=%0d rob=%0d want 1 0 6", ex_b, ex_rs_index, ex_rob_ind); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        issue(4'b0010, 4'd3, 3'd6, 1, 8'd7, 3'd0, 1, 8'd8, 3'd0);
        tick();
        iss_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        n_tests++;
        if ({ex_b, occupancy, iss_ready} !== {1'b0, 2'd0, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid got ex_b=%b occ=%0d rdy=%b want 0 0 1", ex_b, occupancy, iss_ready);
        end
        tick();
        n_tests++; if (ex_b !== 1'b0) begin n_fail++; $display("FAIL rst_mid_dropped ex_b got %b want 0", ex_b); end
    endtask

    task automatic test_bypass();
        do_reset();
        cdb_valid = 1; cdb_tag = 3'd6; cdb_data = 16'h3377;
        issue(4'b0010, 4'd4, 3'd0, 0, 8'd0, 3'd6, 1, 8'd2, 3'd0);
        tick();
        iss_valid = 0;
        cdb_valid = 0;
        tick();
        n_tests++;
`ifdef MUL_RS_CDB_BYPASS_EN
        if ({ex_b, ex_rs1_data, ex_rs2_data} !== {1'b1, 8'h77, 8'd2}) begin
            n_fail++; $display("FAIL bypass got b=%b a=%h b=%h want 1 77 02", ex_b, ex_rs1_data, ex_rs2_data);
        end
`else
        if ({ex_b, occupancy} !== {1'b0, 2'd1}) begin
            n_fail++; $display("FAIL no_bypass got ex_b=%b occ=%0d want 0 1", ex_b, occupancy);
        end
`endif
    endtask

    task automatic model_step();
        int a, s;
        bit legal, b1, b2;
        legal = iss_func == 4'b0010 || iss_func == 4'b0011;
        a = -1;
        s = -1;
        for (int i = 0; i < N; i++) if (a < 0 && m_st[i] == S_FREE) a = i;
        if (!ex_busy && !m_exb)
            foreach (m_age[k]) if (s < 0 && m_st[m_age[k]] == S_READY) s = m_age[k];
        e_ill = iss_valid && !legal;
        e_exb = s >= 0;
        if (s >= 0) e_pkt = {2'(s), m_v1[s], m_v2[s], m_func[s], m_rd[s], m_rob[s]};
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == S_WAIT && cdb_valid) begin
                if (!m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1; m_v1[i] = cdb_data[7:0]; end
                if (!m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1; m_v2[i] = cdb_data[7:0]; end
                if (m_r1[i] && m_r2[i]) m_st[i] = S_READY;
            end
        end
        if (ex_done && m_st[ex_done_idx] == S_EXEC) begin
            m_st[ex_done_idx] = S_FREE;
            for (int k = 0; k < m_age.size(); k++)
                if (m_age[k] == int'(ex_done_idx)) begin m_age.delete(k); break; end
        end
        if (s >= 0) m_st[s] = S_EXEC;
        if (iss_valid && legal && a >= 0) begin
            b1 = 0;
            b2 = 0;
`ifdef MUL_RS_CDB_BYPASS_EN
            b1 = cdb_valid && !iss_s1_rdy && iss_s1_tag == cdb_tag;
            b2 = cdb_valid && !iss_s2_rdy && iss_s2_tag == cdb_tag;
`endif
            m_func[a] = iss_func; m_rd[a] = iss_rd; m_rob[a] = iss_rob;
            m_r1[a] = iss_s1_rdy || b1; m_v1[a] = b1 ? cdb_data[7:0] : iss_s1_val; m_t1[a] = iss_s1_tag;
            m_r2[a] = iss_s2_rdy || b2; m_v2[a] = b2 ? cdb_data[7:0] : iss_s2_val; m_t2[a] = iss_s2_tag;
            m_st[a] = (m_r1[a] && m_r2[a]) ? S_READY : S_WAIT;
            m_age.push_back(a);
        end
        m_exb = e_exb;
        e_occ = 0;
        foreach (m_st[i]) if (m_st[i] != S_FREE) e_occ++;
    endtask

    task automatic test_random();
        do_reset();
        foreach (m_st[i]) m_st[i] = S_FREE;
        m_age.delete();
        m_exb = 0;
        for (int c = 0; c < 600; c++) begin
            iss_valid = $urandom_range(0, 1) == 1;
            iss_func = $urandom_range(0, 7) == 0 ? 4'($urandom) : ($urandom_range(0, 1) == 1 ? 4'b0010 : 4'b0011);
            iss_rd = 4'($urandom); iss_rob = 3'($urandom);
            iss_s1_rdy = $urandom_range(0, 1) == 1; iss_s1_val = 8'($urandom); iss_s1_tag = 3'($urandom_range(0, 3));
            iss_s2_rdy = $urandom_range(0, 1) == 1; iss_s2_val = 8'($urandom); iss_s2_tag = 3'($urandom_range(0, 3));
            cdb_valid = $urandom_range(0, 1) == 1; cdb_tag = 3'($urandom_range(0, 3)); cdb_data = 16'($urandom);
            ex_busy = $urandom_range(0, 3) == 0;
            ex_done = $urandom_range(0, 2) == 0; ex_done_idx = 2'($urandom_range(0, N - 1));
            @(posedge clk1);
            model_step();
            #1;
            n_tests++; if (ex_b !== e_exb) begin n_fail++; $display("FAIL rnd_ex_b cycle %0d got %b want %b", c, ex_b, e_exb); end
            n_tests++; if (occupancy !== 2'(e_occ)) begin n_fail++; $display("FAIL rnd_occ cycle %0d got %0d want %0d", c, occupancy, e_occ); end
            n_tests++; if (iss_ready !== (e_occ < N)) begin n_fail++; $display("FAIL rnd_iss_ready cycle %0d got %b want %b", c, iss_ready, e_occ < N); end
            n_tests++; if (illegal_func !== e_ill) begin n_fail++; $display("FAIL rnd_illegal cycle %0d got %b want %b", c, illegal_func, e_ill); end
            if (e_exb) begin
                n_tests++;
                if ({ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func, ex_rd, ex_rob_ind} !== e_pkt) begin
                    n_fail++; $display("FAIL rnd_fields cycle %0d got %h want %h", c, {ex_rs_index, ex_rs1_data, ex_rs2_data, ex_func, ex_rd, ex_rob_ind}, e_pkt);
                end
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_mul();
        test_wakeup();
        test_full_order();
        test_done_reissue();
        test_illegal();
        test_ignore_done();
        test_rst_mid();
        test_bypass();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
